// File: rtl/seg7_scoreboard.sv
// seg7_scoreboard
//   Shows a binary game score on a multiplexed, common-anode seven-segment bank.
//   A sequential double-dabble converter turns the score into BCD, one bit per
//   clock. Values too large for the digit count saturate to all nines.
//   Leading zeros can be blanked. A rising edge on lose freezes the display,
//   which then flashes until clear is asserted.
// Ports
//   clk    : system clock
//   rst    : asynchronous, active-low reset
//   grade  : binary score (level, sampled whenever the converter is idle)
//   lose   : game-over indication (rising edge freezes the display)
//   clear  : synchronous exit from game-over mode
//   oData  : segments {g,f,e,d,c,b,a}, active-low, registered
//   AN     : digit enables, active-low one-hot, registered
//   busy   : high while a conversion (CONV or LOAD) is in progress
module seg7_scoreboard #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 16,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int FLASH_HZ   = 2,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      grade,
  input  logic                  lose,
  input  logic                  clear,
  output logic [6:0]            oData,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  busy
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int HALF  = CLK_HZ / (2 * FLASH_HZ);
  localparam int PRE_W = $clog2(DWELL);
  localparam int FL_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS) - 64'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] bcd_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Active-low segment pattern for one BCD nibble; non-decimal codes are dark.
  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [1:0]            r_state;
  logic                  r_busy;
  logic [BIN_W-1:0]      r_last_grade;
  logic [BIN_W-1:0]      r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [BCD_W-1:0]      r_disp;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sat;
  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_lose_d;
  logic                  r_frozen;
  logic                  r_phase;
  logic [FL_W-1:0]       r_flash_cnt;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_odata;

  logic [BCD_W-1:0]      w_bcd_adj;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_blank_vec;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_lose_rise;

  // Datapath decode: BCD correction, current digit nibble and blanking mask.
  always_comb begin
    logic z;
    w_bcd_adj   = bcd_adj(r_bcd);
    w_nib       = r_disp[{r_idx, 2'b00} +: 4];
    w_onehot    = NUM_DIGITS'(1) << r_idx;
    w_lose_rise = lose & ~r_lose_d;
    w_blank_vec = '0;
    // z stays set while every nibble from the top down to digit i is zero.
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z && (r_disp[4*i +: 4] == 4'h0);
      w_blank_vec[i] = z;
    end
    if (BLANK_LZ != 0) begin
      w_blank = w_blank_vec[r_idx];
    end else begin
      w_blank = 1'b0;
    end
  end

  // Conversion FSM: latch a changed score, shift it through double-dabble, load the display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_last_grade <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_disp       <= '0;
      r_cnt        <= '0;
      r_sat        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A change that arrived while busy is still pending here, since last_grade lags.
          if (!r_frozen && (grade != r_last_grade)) begin
            r_last_grade <= grade;
            r_bin        <= grade;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_sat        <= (64'(grade) > MAX_VAL);
            r_state      <= ST_CONV;
            r_busy       <= 1'b1;
          end
        end
        ST_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_disp  <= r_sat ? {NUM_DIGITS{4'h9}} : r_bcd;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Game-over control: lose edge detect, frozen flag and flash phase timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lose_d    <= 1'b0;
      r_frozen    <= 1'b0;
      r_phase     <= 1'b1;
      r_flash_cnt <= '0;
    end else begin
      r_lose_d <= lose;
      // The lose edge takes priority over a simultaneous clear.
      if (w_lose_rise) begin
        r_frozen    <= 1'b1;
        r_phase     <= 1'b1;
        r_flash_cnt <= '0;
      end else if (clear) begin
        r_frozen    <= 1'b0;
        r_phase     <= 1'b1;
        r_flash_cnt <= '0;
      end else if (r_frozen) begin
        if (r_flash_cnt == FL_W'(HALF - 1)) begin
          r_flash_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_flash_cnt <= r_flash_cnt + 1'b1;
        end
      end
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      if (r_pre == PRE_W'(DWELL - 1)) begin
        r_pre <= '0;
        if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Registered digit enables and segments; the off flash phase darkens every anode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an    <= '1;
      r_odata <= 7'b1111111;
    end else begin
      r_an    <= (r_frozen && !r_phase) ? '1 : ~w_onehot;
      r_odata <= w_blank ? 7'b1111111 : seg_enc(w_nib);
    end
  end

  assign AN    = r_an;
  assign oData = r_odata;
  assign busy  = r_busy;

endmodule
